// File: rtl/mux8_arb_pkg.sv
// Shared constants and state encoding for the 8-way
// round-robin mux select arbiter.
package mux8_arb_pkg;

    localparam int NREQ  = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request
// at or after ptr, wrapping modulo 8.
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [SEL_W-1:0]  off;

    always_comb begin
        dbl = {req, req};
        // rot[k] is the request at position ptr+k
        rot = dbl[ptr +: NREQ];
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) off = SEL_W'(k);
        end
        found = |req;
        idx   = off + ptr;
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the registered select of
// an 8:1 mux, with a bounded burst per grant.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] sel,
    output logic             gnt_valid,
    output logic [CNT_W-1:0] busy_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0]  gnt_d;
    logic [SEL_W-1:0] sel_d;
    logic             valid_d;
    logic [CNT_W-1:0] cnt_d;

    logic [SEL_W-1:0] next_ptr;
    logic [SEL_W-1:0] pick_ptr;
    logic             found;
    logic [SEL_W-1:0] idx;
    logic             drop;

    // While granted, re-arbitration searches from the slot after the owner
    assign next_ptr = sel + SEL_W'(1);
    assign pick_ptr = (state_q == ST_GRANT) ? next_ptr : ptr_q;
    assign drop     = !req[sel] || (busy_cnt == CNT_MAX);

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (found),
        .idx   (idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt;
        sel_d   = sel;
        valid_d = gnt_valid;
        cnt_d   = busy_cnt;
        unique case (state_q)
            ST_IDLE: begin
                if (en && found) begin
                    state_d = ST_GRANT;
                    gnt_d   = NREQ'(1) << idx;
                    sel_d   = idx;
                    valid_d = 1'b1;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_GRANT: begin
                if (!en) begin
                    ptr_d   = next_ptr;
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    sel_d   = '0;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end else if (drop) begin
                    ptr_d = next_ptr;
                    if (found) begin
                        gnt_d   = NREQ'(1) << idx;
                        sel_d   = idx;
                        valid_d = 1'b1;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        sel_d   = '0;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = busy_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                sel_d   = '0;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt       <= '0;
            sel       <= '0;
            gnt_valid <= 1'b0;
            busy_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt       <= gnt_d;
            sel       <= sel_d;
            gnt_valid <= valid_d;
            busy_cnt  <= cnt_d;
        end
    end

endmodule
